fetch_unit: RTL and testbench

- Instruction-fetch stage directly around the program counter register in the pipelined RISC-V core. Three jobs:
  - Generates the tick_tock phase. The single-ported unified memory serves instruction fetch in phase 0 and data access in phase 1.
  - Computes pc_next, which feeds the PC register. The PC register loads only while tick_tock=0.
  - Captures the fetched instruction into the IF/ID pipeline register, with stall, redirect and flush handling.
- Sits between the PC register and the decode stage. Consumes pc_out and memory read data; produces the IF/ID register contents.

---
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage around the PC register: drives the fetch/data phase,
// computes the next PC and maintains the IF/ID pipeline register.
module fetch_unit #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        tick_tock,
    input  logic [31:0] pc_out,
    input  logic [31:0] mem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc_next,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_inst,
    output logic        ifid_valid,
    output logic [31:0] fetch_count
);

    logic        tick_q;
    logic        pend_q, pend_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        eff_redirect;
    logic [31:0] in_target;
    logic [31:0] eff_target;
    logic [31:0] pc_seq;

    assign in_target    = {redirect_target[31:2], 2'b00};
    assign eff_redirect = redirect_valid | pend_q;
    assign eff_target   = redirect_valid ? in_target : pend_tgt_q;
    assign pc_seq       = pc_out + PC_STEP;

    always_comb begin
        pc_next = pc_seq;
        if (eff_redirect) begin
            pc_next = eff_target;
        end else if (stall) begin
            pc_next = pc_out;
        end
    end

    always_comb begin
        pend_d          = pend_q;
        pend_tgt_d      = pend_tgt_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_inst_d     = ifid_inst_q;
        ifid_valid_d    = ifid_valid_q;
        fetch_count_d   = fetch_count_q;
        if (!tick_q) begin
            if (eff_redirect) begin
                // The redirect is consumed through pc_next this edge.
                pend_d       = 1'b0;
                ifid_inst_d  = NOP_INST;
                ifid_valid_d = 1'b0;
            end else if (!stall) begin
                ifid_pc_d       = pc_out;
                ifid_pc_plus4_d = pc_seq;
                ifid_inst_d     = mem_rdata;
                ifid_valid_d    = 1'b1;
                fetch_count_d   = fetch_count_q + 32'd1;
            end
        end else if (redirect_valid) begin
            // PC cannot load in the data phase, so park the target until phase 0.
            pend_d       = 1'b1;
            pend_tgt_d   = in_target;
            ifid_inst_d  = NOP_INST;
            ifid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q          <= 1'b0;
            pend_q          <= 1'b0;
            pend_tgt_q      <= 32'd0;
            ifid_pc_q       <= 32'd0;
            ifid_pc_plus4_q <= PC_STEP;
            ifid_inst_q     <= NOP_INST;
            ifid_valid_q    <= 1'b0;
            fetch_count_q   <= 32'd0;
        end else begin
            tick_q          <= ~tick_q;
            pend_q          <= pend_d;
            pend_tgt_q      <= pend_tgt_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_inst_q     <= ifid_inst_d;
            ifid_valid_q    <= ifid_valid_d;
            fetch_count_q   <= fetch_count_d;
        end
    end

    assign tick_tock     = tick_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_pc_plus4 = ifid_pc_plus4_q;
    assign ifid_inst     = ifid_inst_q;
    assign ifid_valid    = ifid_valid_q;
    assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random stall/redirect traffic,
// checked against a behavioural model that also plays the PC register.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_tock;
    logic [31:0] pc_out;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc_next;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic [31:0] ifid_inst;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_phase;
    bit          m_pend;
    logic [31:0] m_tgt;
    logic [31:0] m_pcreg;
    logic [31:0] m_ipc;
    logic [31:0] m_ip4;
    logic [31:0] m_inst;
    bit          m_valid;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .tick_tock      (tick_tock),
        .pc_out         (pc_out),
        .mem_rdata      (mem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .pc_next        (pc_next),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus4  (ifid_pc_plus4),
        .ifid_inst      (ifid_inst),
        .ifid_valid     (ifid_valid),
        .fetch_count    (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 1'b0;
        m_pend  = 1'b0;
        m_tgt   = 32'd0;
        m_ipc   = 32'd0;
        m_ip4   = 32'd4;
        m_inst  = NOP;
        m_valid = 1'b0;
        m_cnt   = 32'd0;
    endtask

    function automatic logic [31:0] exp_pc_next();
        if (redirect_valid) return redirect_target & 32'hFFFF_FFFC;
        if (m_pend) return m_tgt;
        if (stall) return pc_out;
        return pc_out + 32'd4;
    endfunction

    task automatic check_state();
        check("tick_tock", {31'd0, tick_tock}, {31'd0, m_phase});
        check("ifid_pc", ifid_pc, m_ipc);
        check("ifid_pc_plus4", ifid_pc_plus4, m_ip4);
        check("ifid_inst", ifid_inst, m_inst);
        check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
        check("fetch_count", fetch_count, m_cnt);
    endtask

    // One clock: drive inputs, check pc_next, clock, advance model, check state.
    task automatic step(input logic st, input logic rv, input logic [31:0] rt);
        logic [31:0] nxt;
        stall           = st;
        redirect_valid  = rv;
        redirect_target = rt;
        mem_rdata       = 32'hA000_0000 | pc_out;
        #1;
        nxt = exp_pc_next();
        check("pc_next", pc_next, nxt);
        @(posedge clk);
        if (!m_phase) begin
            if (rv || m_pend) begin
                m_pend  = 1'b0;
                m_valid = 1'b0;
                m_inst  = NOP;
            end else if (!st) begin
                m_ipc   = pc_out;
                m_ip4   = pc_out + 32'd4;
                m_inst  = mem_rdata;
                m_valid = 1'b1;
                m_cnt   = m_cnt + 32'd1;
            end
            m_pcreg = nxt;
        end else if (rv) begin
            m_pend  = 1'b1;
            m_tgt   = rt & 32'hFFFF_FFFC;
            m_valid = 1'b0;
            m_inst  = NOP;
        end
        m_phase = ~m_phase;
        #1;
        pc_out = m_pcreg;
        check_state();
    endtask

    // Pulse reset in the middle of a cycle and check the immediate effect.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_state();
        check("rst_pc_next", pc_next, exp_pc_next());
        #2 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pc_out = 32'd0;
        mem_rdata = 32'd0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'd0;
        m_pcreg = 32'd0;
        model_reset();
        #3;
        check_state();
        #9 rst = 1'b0;

        // Sequential fetch from 0
        step(1'b0, 1'b0, 32'd0);
        check("first_inst", ifid_inst, 32'hA000_0000);
        check("first_count", fetch_count, 32'd1);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check("second_pc", ifid_pc, 32'd4);
        check("second_count", fetch_count, 32'd2);
        step(1'b0, 1'b0, 32'd0);
        // Phase-0 stall at pc 8
        step(1'b1, 1'b0, 32'd0);
        check("stall_hold_pc", ifid_pc, 32'd4);
        step(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0);
        check("pc_at_0x10", pc_out, 32'h10);
        // Phase-0 redirect with simultaneous stall
        step(1'b1, 1'b1, 32'h100);
        check("redir_bubble", ifid_inst, NOP);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check("redir_target_pc", ifid_pc, 32'h100);
        check("redir_target_valid", {31'd0, ifid_valid}, 32'd1);
        // Phase-1 redirect, misaligned target
        step(1'b0, 1'b1, 32'h203);
        check("p1_flush", {31'd0, ifid_valid}, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check("p1_redir_pc", pc_out, 32'h200);
        step(1'b0, 1'b0, 32'd0);
        // PC wrap
        pc_out  = 32'hFFFF_FFFC;
        m_pcreg = 32'hFFFF_FFFC;
        step(1'b0, 1'b0, 32'd0);
        check("wrap_plus4", ifid_pc_plus4, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        // Pending redirect discarded by reset
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'h300);
        mid_reset();
        step(1'b0, 1'b0, 32'd0);
        check("post_rst_pc", pc_out, 32'd8);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic        st;
            logic        rv;
            logic [31:0] rt;
            st = ($urandom_range(3) == 0);
            rv = ($urandom_range(7) == 0);
            rt = $urandom;
            if ($urandom_range(49) == 0) begin
                pc_out  = $urandom & 32'hFFFF_FFFC;
                m_pcreg = pc_out;
            end
            step(st, rv, rt);
            if ($urandom_range(99) == 0) mid_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
